// File: rtl/axi_master_bridge.sv
// AXI4 master bridge shared by IFU and LSU: one outstanding transaction, LSU priority.
// Optional macro AXI_ID_CHECK_EN adds a sticky ID/beat-count protocol_err monitor.
module axi_master_bridge #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int IFU_ID    = 0,
  parameter int LSU_ID    = 1,
  parameter int IFU_BEATS = 1
) (
  input  logic                clock,
  input  logic                reset,
  output logic                io_master_awvalid,
  input  logic                io_master_awready,
  output logic [ADDR_W-1:0]   io_master_awaddr,
  output logic [ID_W-1:0]     io_master_awid,
  output logic [7:0]          io_master_awlen,
  output logic [2:0]          io_master_awsize,
  output logic [1:0]          io_master_awburst,
  output logic                io_master_wvalid,
  input  logic                io_master_wready,
  output logic [DATA_W-1:0]   io_master_wdata,
  output logic [DATA_W/8-1:0] io_master_wstrb,
  output logic                io_master_wlast,
  input  logic                io_master_bvalid,
  output logic                io_master_bready,
  input  logic [1:0]          io_master_bresp,
  input  logic [ID_W-1:0]     io_master_bid,
  output logic                io_master_arvalid,
  input  logic                io_master_arready,
  output logic [ADDR_W-1:0]   io_master_araddr,
  output logic [ID_W-1:0]     io_master_arid,
  output logic [7:0]          io_master_arlen,
  output logic [2:0]          io_master_arsize,
  output logic [1:0]          io_master_arburst,
  input  logic                io_master_rvalid,
  output logic                io_master_rready,
  input  logic [DATA_W-1:0]   io_master_rdata,
  input  logic [1:0]          io_master_rresp,
  input  logic                io_master_rlast,
  input  logic [ID_W-1:0]     io_master_rid,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  output logic                ifu_rsp_last,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_wen,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic [2:0]          lsu_size,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_rdata,
  output logic                lsu_rsp_err,
  output logic                protocol_err
);

  localparam logic [2:0]      IFU_SIZE  = 3'($clog2(DATA_W/8));
  localparam logic [7:0]      IFU_LEN   = 8'(IFU_BEATS - 1);
  localparam logic [ID_W-1:0] IFU_ID_V  = ID_W'(IFU_ID);
  localparam logic [ID_W-1:0] LSU_ID_V  = ID_W'(LSU_ID);
  localparam logic [1:0]      BURST_INC = 2'b01;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_wstrb;
  logic [2:0]          req_size;
  logic                req_ifu;
  logic                aw_done, w_done;
  logic [7:0]          beat_cnt;
  logic                accept;
  logic [ID_W-1:0]     req_id;
  logic [7:0]          req_len;

  assign accept  = (state == IDLE) && (lsu_req_valid || ifu_req_valid);
  assign req_id  = req_ifu ? IFU_ID_V : LSU_ID_V;
  assign req_len = req_ifu ? IFU_LEN : 8'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (lsu_req_valid)      state_nxt = lsu_wen ? WR_REQ : RD_ADDR;
        else if (ifu_req_valid) state_nxt = RD_ADDR;
      end
      RD_ADDR: if (io_master_arready) state_nxt = RD_DATA;
      RD_DATA: if (io_master_rvalid && io_master_rlast) state_nxt = IDLE;
      // Either channel may have completed earlier; a same-cycle pair also counts.
      WR_REQ:  if ((aw_done || io_master_awready) && (w_done || io_master_wready))
                 state_nxt = WR_RESP;
      WR_RESP: if (io_master_bvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ifu_req_ready     = 1'b0;
    lsu_req_ready     = 1'b0;
    io_master_arvalid = 1'b0;
    io_master_rready  = 1'b0;
    io_master_awvalid = 1'b0;
    io_master_wvalid  = 1'b0;
    io_master_bready  = 1'b0;
    ifu_rsp_valid     = 1'b0;
    ifu_rsp_last      = 1'b0;
    ifu_rsp_err       = 1'b0;
    lsu_rsp_valid     = 1'b0;
    lsu_rsp_err       = 1'b0;
    case (state)
      IDLE: begin
        lsu_req_ready = lsu_req_valid;
        ifu_req_ready = ifu_req_valid && !lsu_req_valid;
      end
      RD_ADDR: io_master_arvalid = 1'b1;
      RD_DATA: begin
        io_master_rready = 1'b1;
        ifu_rsp_valid    = io_master_rvalid && req_ifu;
        ifu_rsp_last     = io_master_rvalid && req_ifu && io_master_rlast;
        ifu_rsp_err      = io_master_rvalid && req_ifu && (io_master_rresp != 2'b00);
        lsu_rsp_valid    = io_master_rvalid && !req_ifu;
        lsu_rsp_err      = io_master_rvalid && !req_ifu && (io_master_rresp != 2'b00);
      end
      WR_REQ: begin
        io_master_awvalid = !aw_done;
        io_master_wvalid  = !w_done;
      end
      WR_RESP: begin
        io_master_bready = 1'b1;
        lsu_rsp_valid    = io_master_bvalid;
        lsu_rsp_err      = io_master_bvalid && (io_master_bresp != 2'b00);
      end
      default: ;
    endcase
  end

  assign io_master_araddr  = req_addr;
  assign io_master_arid    = req_id;
  assign io_master_arlen   = req_len;
  assign io_master_arsize  = req_size;
  assign io_master_arburst = BURST_INC;
  assign io_master_awaddr  = req_addr;
  assign io_master_awid    = LSU_ID_V;
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = req_size;
  assign io_master_awburst = BURST_INC;
  assign io_master_wdata   = req_wdata;
  assign io_master_wstrb   = req_wstrb;
  assign io_master_wlast   = io_master_wvalid;
  assign ifu_rsp_data      = io_master_rdata;
  assign lsu_rsp_rdata     = io_master_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      req_size  <= '0;
      req_ifu   <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      if (accept) begin
        req_ifu   <= !lsu_req_valid;
        req_addr  <= lsu_req_valid ? lsu_addr : ifu_addr;
        req_wdata <= lsu_wdata;
        req_wstrb <= lsu_wstrb;
        req_size  <= lsu_req_valid ? lsu_size : IFU_SIZE;
        beat_cnt  <= '0;
      end else if (state == RD_DATA && io_master_rvalid) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (state == WR_REQ) begin
        if (io_master_awvalid && io_master_awready) aw_done <= 1'b1;
        if (io_master_wvalid && io_master_wready)   w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

`ifdef AXI_ID_CHECK_EN
  logic r_bad, b_bad;
  // A non-final beat at or past arlen means rlast is late; rlast before arlen means early.
  assign r_bad = (state == RD_DATA) && io_master_rvalid &&
                 ((io_master_rid != req_id) ||
                  (io_master_rlast ? (beat_cnt != req_len) : (beat_cnt >= req_len)));
  assign b_bad = (state == WR_RESP) && io_master_bvalid && (io_master_bid != LSU_ID_V);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)              protocol_err <= 1'b0;
    else if (r_bad || b_bad) protocol_err <= 1'b1;
  end
`else
  logic unused_ids;
  assign unused_ids   = ^{io_master_rid, io_master_bid, beat_cnt};
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_master_bridge.sv
// Directed self-checking bench for axi_master_bridge with a hand-driven AXI slave (IFU_BEATS=4).
module tb_axi_master_bridge;
  logic        clock = 1'b0;
  logic        reset;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awid, arid, bid, rid, wstrb;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_last, ifu_rsp_err;
  logic [31:0] ifu_addr, ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rsp_rdata;
  logic [3:0]  lsu_wstrb;
  logic [2:0]  lsu_size;
  logic        protocol_err;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  axi_master_bridge #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .IFU_ID(0), .LSU_ID(1), .IFU_BEATS(4)) dut (
    .clock(clock), .reset(reset),
    .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
    .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize), .io_master_awburst(awburst),
    .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bvalid(bvalid), .io_master_bready(bready), .io_master_bresp(bresp), .io_master_bid(bid),
    .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
    .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize), .io_master_arburst(arburst),
    .io_master_rvalid(rvalid), .io_master_rready(rready), .io_master_rdata(rdata),
    .io_master_rresp(rresp), .io_master_rlast(rlast), .io_master_rid(rid),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_last(ifu_rsp_last),
    .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_size(lsu_size),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
    .protocol_err(protocol_err)
  );

  // Slave R beat presented at the negedge so it is consumed on the next posedge.
  task automatic drive_beat(input logic [31:0] d, input logic l, input logic [1:0] resp, input logic [3:0] id);
    @(negedge clock);
    arready = 1'b0; rvalid = 1'b1; rdata = d; rlast = l; rresp = resp; rid = id;
    #1;
  endtask

  task automatic end_beats();
    @(negedge clock);
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL rst_arvalid got=%b exp=0", arvalid); end
    checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin failures++; $display("FAIL rst_aw_w got=%b%b exp=00", awvalid, wvalid); end
    checks++; if (rready !== 1'b0 || bready !== 1'b0) begin failures++; $display("FAIL rst_rb_ready got=%b%b exp=00", rready, bready); end
    checks++; if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp got=%b%b exp=00", ifu_rsp_valid, lsu_rsp_valid); end
    checks++; if (lsu_req_ready !== 1'b0 || ifu_req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b%b exp=00", lsu_req_ready, ifu_req_ready); end
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL rst_protocol_err got=%b exp=0", protocol_err); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_ifu_burst();
    @(negedge clock);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
    #1;
    checks++; if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL ifu_req_ready got=%b exp=1", ifu_req_ready); end
    @(negedge clock);
    ifu_req_valid = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b1) begin failures++; $display("FAIL ifu_arvalid got=%b exp=1", arvalid); end
    checks++; if (araddr !== 32'h8000_0010) begin failures++; $display("FAIL ifu_araddr got=%h exp=80000010", araddr); end
    checks++; if (arlen !== 8'd3 || arid !== 4'd0) begin failures++; $display("FAIL ifu_arlen_id got=%0d/%0d exp=3/0", arlen, arid); end
    checks++; if (arsize !== 3'd2 || arburst !== 2'b01) begin failures++; $display("FAIL ifu_arsize_burst got=%0d/%0d exp=2/1", arsize, arburst); end
    @(negedge clock);
    #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0010) begin failures++; $display("FAIL ifu_ar_hold got=%b/%h exp=1/80000010", arvalid, araddr); end
    arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(32'h11 * (i + 1), (i == 3), 2'b00, 4'd0);
      checks++; if (rready !== 1'b1 || ifu_rsp_valid !== 1'b1) begin failures++; $display("FAIL ifu_beat%0d_valid got=%b%b exp=11", i, rready, ifu_rsp_valid); end
      checks++; if (ifu_rsp_data !== 32'h11 * (i + 1)) begin failures++; $display("FAIL ifu_beat%0d_data got=%h exp=%h", i, ifu_rsp_data, 32'h11 * (i + 1)); end
      checks++; if (ifu_rsp_last !== (i == 3)) begin failures++; $display("FAIL ifu_beat%0d_last got=%b exp=%b", i, ifu_rsp_last, (i == 3)); end
      checks++; if (lsu_rsp_valid !== 1'b0) begin failures++; $display("FAIL ifu_beat%0d_lsu got=%b exp=0", i, lsu_rsp_valid); end
    end
    end_beats();
    checks++; if (rready !== 1'b0 || ifu_rsp_valid !== 1'b0) begin failures++; $display("FAIL ifu_done got=%b%b exp=00", rready, ifu_rsp_valid); end
  endtask

  task automatic test_priority();
    @(negedge clock);
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_0040;
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h0000_0100; lsu_size = 3'd0;
    #1;
    checks++; if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin failures++; $display("FAIL prio_ready got=%b%b exp=10", lsu_req_ready, ifu_req_ready); end
    @(negedge clock);
    lsu_req_valid = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h100) begin failures++; $display("FAIL lsu_ar got=%b/%h exp=1/00000100", arvalid, araddr); end
    checks++; if (arsize !== 3'd0 || arid !== 4'd1 || arlen !== 8'd0) begin failures++; $display("FAIL lsu_ar_ctl got=%0d/%0d/%0d exp=0/1/0", arsize, arid, arlen); end
    checks++; if (ifu_req_ready !== 1'b0) begin failures++; $display("FAIL busy_ifu_ready got=%b exp=0", ifu_req_ready); end
    arready = 1'b1;
    drive_beat(32'h0000_00A5, 1'b1, 2'b00, 4'd1);
    checks++; if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== 32'hA5 || lsu_rsp_err !== 1'b0) begin failures++; $display("FAIL lsu_load got=%b/%h/%b exp=1/000000a5/0", lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err); end
    checks++; if (ifu_rsp_valid !== 1'b0) begin failures++; $display("FAIL lsu_load_ifu got=%b exp=0", ifu_rsp_valid); end
    end_beats();
    checks++; if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ifu_ready got=%b exp=1", ifu_req_ready); end
    @(negedge clock);
    ifu_req_valid = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h40 || arid !== 4'd0 || arlen !== 8'd3 || arsize !== 3'd2) begin failures++; $display("FAIL ifu_after_ar got=%b/%h/%0d/%0d/%0d exp=1/00000040/0/3/2", arvalid, araddr, arid, arlen, arsize); end
    arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(32'h100 + i, (i == 3), (i == 1) ? 2'b10 : 2'b00, 4'd0);
      checks++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_err !== (i == 1)) begin failures++; $display("FAIL ifu_err_beat%0d got=%b/%b exp=1/%b", i, ifu_rsp_valid, ifu_rsp_err, (i == 1)); end
    end
    end_beats();
  endtask

  task automatic test_store_aw_first();
    @(negedge clock);
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h200; lsu_wdata = 32'hDEAD_BEEF;
    lsu_wstrb = 4'hF; lsu_size = 3'd2;
    @(negedge clock);
    lsu_req_valid = 1'b0;
    #1;
    checks++; if (awvalid !== 1'b1 || wvalid !== 1'b1) begin failures++; $display("FAIL st_aw_w got=%b%b exp=11", awvalid, wvalid); end
    checks++; if (awaddr !== 32'h200 || awid !== 4'd1 || awlen !== 8'd0 || awsize !== 3'd2) begin failures++; $display("FAIL st_aw_ctl got=%h/%0d/%0d/%0d exp=00000200/1/0/2", awaddr, awid, awlen, awsize); end
    checks++; if (wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF || wlast !== 1'b1) begin failures++; $display("FAIL st_w got=%h/%h/%b exp=deadbeef/f/1", wdata, wstrb, wlast); end
    awready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      awready = 1'b0;
      #1;
      checks++; if (awvalid !== 1'b0 || wvalid !== 1'b1 || lsu_rsp_valid !== 1'b0) begin failures++; $display("FAIL st_wait%0d got=%b%b%b exp=010", k, awvalid, wvalid, lsu_rsp_valid); end
    end
    @(negedge clock);
    wready = 1'b1;
    @(negedge clock);
    wready = 1'b0;
    #1;
    checks++; if (wvalid !== 1'b0 || bready !== 1'b1 || lsu_rsp_valid !== 1'b0) begin failures++; $display("FAIL st_wresp got=%b%b%b exp=010", wvalid, bready, lsu_rsp_valid); end
    @(negedge clock);
    bvalid = 1'b1; bresp = 2'b10; bid = 4'd1;
    #1;
    checks++; if (lsu_rsp_valid !== 1'b1 || lsu_rsp_err !== 1'b1) begin failures++; $display("FAIL st_bresp got=%b/%b exp=1/1", lsu_rsp_valid, lsu_rsp_err); end
    @(negedge clock);
    bvalid = 1'b0; bresp = 2'b00;
    #1;
    checks++; if (bready !== 1'b0 || lsu_rsp_valid !== 1'b0) begin failures++; $display("FAIL st_done got=%b%b exp=00", bready, lsu_rsp_valid); end
  endtask

  task automatic test_store_same_cycle();
    int pulses = 0;
    @(negedge clock);
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h300; lsu_wdata = 32'h1234_5678;
    lsu_wstrb = 4'h3; lsu_size = 3'd1;
    @(negedge clock);
    lsu_req_valid = 1'b0; awready = 1'b1; wready = 1'b1;
    #1;
    checks++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || wstrb !== 4'h3 || awsize !== 3'd1) begin failures++; $display("FAIL sc_issue got=%b%b/%h/%0d exp=11/3/1", awvalid, wvalid, wstrb, awsize); end
    @(negedge clock);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b00; bid = 4'd1;
    #1;
    checks++; if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin failures++; $display("FAIL sc_wresp got=%b%b%b exp=100", bready, awvalid, wvalid); end
    checks++; if (lsu_rsp_err !== 1'b0) begin failures++; $display("FAIL sc_err got=%b exp=0", lsu_rsp_err); end
    if (lsu_rsp_valid === 1'b1) pulses++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      bvalid = 1'b0;
      #1;
      if (lsu_rsp_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL sc_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    ifu_req_valid = 1'b1; ifu_addr = 32'h1000;
    @(negedge clock);
    ifu_req_valid = 1'b0; arready = 1'b1;
    drive_beat(32'hAA, 1'b0, 2'b00, 4'd0);
    drive_beat(32'hBB, 1'b0, 2'b00, 4'd0);
    checks++; if (ifu_rsp_valid !== 1'b1) begin failures++; $display("FAIL rm_beat2 got=%b exp=1", ifu_rsp_valid); end
    reset = 1'b1;
    #1;
    checks++; if (rready !== 1'b0 || ifu_rsp_valid !== 1'b0 || arvalid !== 1'b0) begin failures++; $display("FAIL rm_drop got=%b%b%b exp=000", rready, ifu_rsp_valid, arvalid); end
    checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0) begin failures++; $display("FAIL rm_drop_w got=%b%b%b exp=000", awvalid, wvalid, bready); end
    rvalid = 1'b0;
    @(negedge clock);
    reset = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h2000;
    #1;
    checks++; if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL rm_idle got=%b exp=1", ifu_req_ready); end
    @(negedge clock);
    ifu_req_valid = 1'b0; arready = 1'b1;
    #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h2000) begin failures++; $display("FAIL rm_refetch got=%b/%h exp=1/00002000", arvalid, araddr); end
    for (int i = 0; i < 4; i++) drive_beat(32'h5000 + i, (i == 3), 2'b00, 4'd0);
    checks++; if (ifu_rsp_last !== 1'b1 || ifu_rsp_data !== 32'h5003) begin failures++; $display("FAIL rm_last got=%b/%h exp=1/00005003", ifu_rsp_last, ifu_rsp_data); end
    end_beats();
  endtask

`ifdef AXI_ID_CHECK_EN
  task automatic test_id_check();
    @(negedge clock);
    ifu_req_valid = 1'b1; ifu_addr = 32'h3000;
    @(negedge clock);
    ifu_req_valid = 1'b0; arready = 1'b1;
    for (int i = 0; i < 4; i++) drive_beat(32'h6000 + i, (i == 3), 2'b00, 4'd5);
    end_beats();
    checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL idc_set got=%b exp=1", protocol_err); end
    @(negedge clock);
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h400; lsu_size = 3'd2;
    @(negedge clock);
    lsu_req_valid = 1'b0; arready = 1'b1;
    drive_beat(32'h77, 1'b1, 2'b00, 4'd1);
    end_beats();
    checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL idc_sticky got=%b exp=1", protocol_err); end
    reset = 1'b1;
    #1;
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL idc_clear got=%b exp=0", protocol_err); end
    @(negedge clock);
    reset = 1'b0;
  endtask
`endif

  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_size = 0;
    test_reset();
    test_ifu_burst();
    test_priority();
    test_store_aw_first();
    test_store_same_cycle();
    test_reset_mid();
`ifdef AXI_ID_CHECK_EN
    test_id_check();
`else
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL no_idc_err got=%b exp=0", protocol_err); end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
